// File: rtl/npu_bias_pkg.sv
// rtl/npu_bias_pkg.sv - shared constants and FSM type for the bias fetch path
package npu_bias_pkg;

  localparam int BIAS_LANES  = 16;
  localparam int BIAS_LANE_W = 32;
  localparam int BIAS_ADDR_W = 8;
  localparam int BIAS_DATA_W = BIAS_LANES * BIAS_LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bias_fetch_state_t;

endpackage

// File: rtl/bias_fetch_ctrl_if.sv
// rtl/bias_fetch_ctrl_if.sv - command, bias buffer read port and vector stream bundle
interface bias_fetch_ctrl_if
  import npu_bias_pkg::*;
#(
  parameter int ADDR_W = BIAS_ADDR_W,
  parameter int DATA_W = BIAS_DATA_W
);

  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [ADDR_W:0]   i_grp_num;
  logic              o_busy;
  logic              o_done;
  logic              o_bias_rd_en;
  logic [ADDR_W-1:0] o_bias_raddr;
  logic [DATA_W-1:0] i_bias_data;
  logic              i_bias_data_vld;
  logic [DATA_W-1:0] o_bias_vec;
  logic              o_bias_vld;
  logic              i_bias_rdy;

  modport slave (
    input  i_start, i_base_addr, i_grp_num, i_bias_data, i_bias_data_vld, i_bias_rdy,
    output o_busy, o_done, o_bias_rd_en, o_bias_raddr, o_bias_vec, o_bias_vld
  );

  modport master (
    output i_start, i_base_addr, i_grp_num, i_bias_data, i_bias_data_vld, i_bias_rdy,
    input  o_busy, o_done, o_bias_rd_en, o_bias_raddr, o_bias_vec, o_bias_vld
  );

endinterface

// File: rtl/bias_vec_fifo.sv
// rtl/bias_vec_fifo.sv - return-data FIFO with registered head and count
module bias_vec_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 512,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             pop_ok;

  // next pointer/count and the entry that becomes head after this edge
  always_comb begin
    pop_ok    = pop && (count != '0);
    rd_nxt    = rd_ptr + PTR_W'(pop_ok);
    count_nxt = count + CNT_W'(push) - CNT_W'(pop_ok);
    head_nxt  = (push && (rd_nxt == wr_ptr)) ? wdata : mem[rd_nxt];
  end

  // storage array, written on push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // pointers, count and registered head
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      if (count_nxt != '0) head <= head_nxt;
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/bias_fetch_ctrl.sv
// rtl/bias_fetch_ctrl.sv - bias buffer read controller with latency-absorbing return FIFO
module bias_fetch_ctrl
  import npu_bias_pkg::*;
#(
  parameter int ADDR_W     = BIAS_ADDR_W,
  parameter int DATA_W     = BIAS_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  bias_fetch_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  bias_fetch_state_t state, state_nxt;
  logic [ADDR_W:0]   rd_left, out_left;
  logic [ADDR_W-1:0] next_addr, issue_addr, raddr_q;
  logic              rd_en_q;
  logic              accept, push, pop, fifo_vld;
  logic              issue, credit, busy, done;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    inflight;
  logic [DATA_W-1:0] fifo_head;

  assign accept     = (state == ST_IDLE) && bus.i_start;
  assign push       = bus.i_bias_data_vld && ((state == ST_FETCH) || (state == ST_DRAIN));
  assign fifo_vld   = (fifo_count != '0);
  assign pop        = fifo_vld && bus.i_bias_rdy;
  assign issue_addr = (state == ST_IDLE) ? bus.i_base_addr : next_addr;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // next-state: leave FETCH on the last issued read, leave DRAIN on the last handshake
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.i_start) state_nxt = (bus.i_grp_num == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if ((rd_left == '0) || (issue && (rd_left == (ADDR_W+1)'(1)))) state_nxt = ST_DRAIN;
      ST_DRAIN: if ((out_left == '0) || (pop && (out_left == (ADDR_W+1)'(1)))) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // status outputs and read issue; credit counts stored + in-flight words, ignoring pops
  always_comb begin
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    inflight = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_en_q} + {{CNT_W{1'b0}}, push};
    credit   = (inflight < (CNT_W+1)'(FIFO_DEPTH));
    issue    = (accept && (bus.i_grp_num != '0)) ||
               ((state == ST_FETCH) && (rd_left != '0) && credit);
  end

  // registered read port and the read/handshake counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_en_q   <= 1'b0;
      raddr_q   <= '0;
      next_addr <= '0;
      rd_left   <= '0;
      out_left  <= '0;
    end else begin
      rd_en_q <= issue;
      if (issue) begin
        raddr_q   <= issue_addr;
        next_addr <= issue_addr + ADDR_W'(1);
      end
      rd_left <= (accept ? bus.i_grp_num : rd_left) - {{ADDR_W{1'b0}}, issue};
      if (accept)                        out_left <= bus.i_grp_num;
      else if (pop && (out_left != '0)) out_left <= out_left - (ADDR_W+1)'(1);
    end
  end

  bias_vec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (bus.i_bias_data),
    .pop   (pop),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign bus.o_busy       = busy;
  assign bus.o_done       = done;
  assign bus.o_bias_rd_en = rd_en_q;
  assign bus.o_bias_raddr = raddr_q;
  assign bus.o_bias_vec   = fifo_head;
  assign bus.o_bias_vld   = fifo_vld;

endmodule

// File: tb/tb_bias_fetch_ctrl.sv
// tb/tb_bias_fetch_ctrl.sv - randomized self-checking bench for bias_fetch_ctrl
module tb_bias_fetch_ctrl;
  import npu_bias_pkg::*;

  localparam int ADDR_W = BIAS_ADDR_W;
  localparam int DATA_W = BIAS_DATA_W;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bias_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bias_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] salt;

  function automatic logic [DATA_W-1:0] bias_word(input logic [ADDR_W-1:0] a, input logic [15:0] s);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < BIAS_LANES; i++) w[i*32 +: 32] = {s, 8'(i), a};
    return w;
  endfunction

  // bias buffer: fixed one-cycle read latency
  logic              buf_vld;
  logic              stray_vld;
  logic [DATA_W-1:0] buf_data;
  always @(posedge clk) begin
    buf_vld  <= bus.o_bias_rd_en;
    buf_data <= bias_word(bus.o_bias_raddr, salt);
  end
  always_comb bus.i_bias_data_vld = buf_vld | stray_vld;
  always_comb bus.i_bias_data     = buf_data;

  // mode 0: rdy always 1, mode 1: rdy 0 through cycle 10, mode 2: random rdy
  task automatic run_cmd(input logic [ADDR_W-1:0] base, input int num, input int mode, input int rst_at);
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] hold_vec;
    int cyc, reads, hs, first_rd, last_rd, first_vld, done_cyc, last_hs, max_out, reads_at10;
    bit finished, aborted, hold_ok, rdy_now;
    salt = 16'($urandom);
    for (int k = 0; k < num; k++) begin
      a = base + ADDR_W'(k);
      addr_q.push_back(a);
      exp_q.push_back(bias_word(a, salt));
    end
    cyc = 0; reads = 0; hs = 0; first_rd = -1; last_rd = -1; first_vld = -1;
    done_cyc = -1; last_hs = 0; max_out = 0; reads_at10 = 0;
    finished = 0; aborted = 0; hold_ok = 0; hold_vec = '0;
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_base_addr = base;
    bus.i_grp_num   = (ADDR_W+1)'(num);
    bus.i_bias_rdy  = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    while (!finished && !aborted && cyc < 1500) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.i_base_addr = ADDR_W'($urandom);
        bus.i_grp_num   = (ADDR_W+1)'($urandom_range(0, 256));
      end
      if (cyc == 2) bus.i_start = 1'b0;
      if (rst_at >= 0 && hs == rst_at) begin
        rst = 1'b0;
        bus.i_start = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", {bus.o_busy, bus.o_done, bus.o_bias_rd_en, bus.o_bias_vld, bus.o_bias_raddr}, '0);
        chk("rst_vec", bus.o_bias_vec, '0);
        rst = 1'b1;
        stray_vld = 1'b1;
        @(negedge clk);
        chk("stray_dropped", {bus.o_bias_vld, bus.o_busy}, '0);
        stray_vld = 1'b0;
        aborted = 1;
      end else begin
        rdy_now = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc > 10) : ($urandom_range(0, 3) != 0);
        bus.i_bias_rdy = rdy_now;
        if (bus.o_bias_rd_en) begin
          reads++;
          if (first_rd < 0) first_rd = cyc;
          last_rd = cyc;
          if (addr_q.size() == 0) chk("extra_read", 1, 0);
          else chk("raddr", bus.o_bias_raddr, addr_q.pop_front());
        end
        if (cyc == 10) reads_at10 = reads;
        if (reads - hs > max_out) max_out = reads - hs;
        if (bus.o_bias_vld) begin
          if (first_vld < 0) first_vld = cyc;
          if (hold_ok) chk("hold_stable", bus.o_bias_vec, hold_vec);
        end
        if (bus.o_bias_vld && rdy_now) begin
          hs++;
          last_hs = cyc;
          if (exp_q.size() == 0) chk("extra_vec", 1, 0);
          else chk("vec", bus.o_bias_vec, exp_q.pop_front());
        end
        hold_ok  = bus.o_bias_vld && !rdy_now;
        hold_vec = bus.o_bias_vec;
        if (bus.o_done) begin
          done_cyc = cyc;
          finished = 1;
        end
      end
    end
    if (!aborted) begin
      if (!finished) chk("timeout", 0, 1);
      @(negedge clk);
      chk("idle_after_done", {bus.o_busy, bus.o_done, bus.o_bias_rd_en}, '0);
      bus.i_start = 1'b0;
      chk("handshakes", hs, num);
      chk("reads", reads, num);
      chk("outstanding_le_depth", (max_out <= DEPTH), 1);
      chk("done_cycle", done_cyc, (num == 0) ? 1 : last_hs + 1);
      if (mode == 0 && num > 0) begin
        chk("first_rd_cycle", first_rd, 1);
        chk("last_rd_cycle", last_rd, num);
        chk("first_vld_cycle", first_vld, 3);
        chk("done_latency", done_cyc, num + 3);
      end
      if (mode == 1) chk("stall_reads", reads_at10, (num < DEPTH) ? num : DEPTH);
    end
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_grp_num = '0; bus.i_bias_rdy = 1'b0;
    stray_vld = 1'b0; salt = '0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("reset_ctrl", {bus.o_busy, bus.o_done, bus.o_bias_rd_en, bus.o_bias_vld, bus.o_bias_raddr}, '0);
        chk("reset_vec", bus.o_bias_vec, '0);
      end
      bus.i_start     = 1'($urandom);
      bus.i_base_addr = ADDR_W'($urandom);
      bus.i_grp_num   = (ADDR_W+1)'($urandom_range(0, 256));
      bus.i_bias_rdy  = 1'($urandom);
      stray_vld       = 1'b1;
    end
    @(negedge clk);
    chk("reset_end", {bus.o_busy, bus.o_done, bus.o_bias_rd_en, bus.o_bias_vld, bus.o_bias_raddr}, '0);
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_bias_rdy = 1'b1;
    @(negedge clk);
    chk("post_reset_stray", {bus.o_bias_vld, bus.o_busy}, '0);
    stray_vld = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {bus.o_bias_vld, bus.o_busy, bus.o_bias_rd_en}, '0);

    run_cmd(8'h10, 4, 0, -1);
    run_cmd(8'hFE, 4, 0, -1);
    run_cmd(8'h00, 8, 1, -1);
    run_cmd(8'h33, 0, 0, -1);
    run_cmd(8'h40, 16, 0, 2);
    run_cmd(8'h20, 2, 0, -1);
    run_cmd(ADDR_W'($urandom), 1, 0, -1);
    for (int t = 0; t < 10; t++) run_cmd(ADDR_W'($urandom), $urandom_range(1, 40), 2, -1);
    run_cmd(ADDR_W'($urandom), 256, 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
